// File: rtl/cbrt_seq.sv
`default_nettype none
// ============================================================================
//  Module   : cbrt_seq
//  Purpose  : Sequential integer cube root, result = floor(cbrt(x)),
//             remainder = x - result^3. Digit-by-digit method, 3 operand bits
//             per result bit. All additions go through an external shared
//             adder (sum_in_a + sum_in_b -> sum_out).
//  Revision : 1.0 - initial release
// ============================================================================
module cbrt_seq #(
  parameter int WIDTH = 8,
  parameter int Y_W   = (WIDTH + 2) / 3,
  parameter int SUM_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] x_i,
  output logic             busy,
  output logic             done,
  output logic [Y_W-1:0]   result,
  output logic [WIDTH-1:0] remainder,
  output logic [SUM_W-1:0] sum_in_a,
  output logic [SUM_W-1:0] sum_in_b,
  input  logic [SUM_W-1:0] sum_out
);

  // Shift amount s runs 3*(Y_W-1) .. 0, multiplier step k runs 0 .. Y_W-1.
  localparam int S_W = $clog2(3 * Y_W + 1);
  localparam int K_W = $clog2(Y_W + 1);

  localparam logic [S_W-1:0] S_INIT = S_W'(3 * (Y_W - 1));
  localparam logic [K_W-1:0] K_LAST = K_W'(Y_W - 1);

  // Parameter sanity, caught at elaboration.
  if (WIDTH < 3) begin : g_chk_width
    $error("cbrt_seq: WIDTH must be at least 3");
  end
  if (Y_W != (WIDTH + 2) / 3) begin : g_chk_yw
    $error("cbrt_seq: Y_W is derived from WIDTH and must not be overridden");
  end
  if (SUM_W < 3 * Y_W + 3) begin : g_chk_sumw
    $error("cbrt_seq: SUM_W must be at least 3*Y_W+3");
  end

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SHIFT  = 3'd1,
    ST_MUL    = 3'd2,
    ST_TRIPLE = 3'd3,
    ST_SUB    = 3'd4
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] rem_q;
  logic [Y_W-1:0]   y_q;
  logic [SUM_W-1:0] acc_q;
  logic [S_W-1:0]   s_q;
  logic [K_W-1:0]   k_q;
  logic             busy_q;
  logic             done_q;
  logic [Y_W-1:0]   result_q;
  logic [WIDTH-1:0] remainder_q;

  // Multiplier partial product. y is even in MUL (freshly doubled), so y+1
  // is simply y with bit 0 set -- no carry, no adder needed.
  logic [Y_W-1:0]   yp1;
  logic [Y_W-1:0]   kmask;
  logic             pp_bit;
  logic [SUM_W-1:0] pp;

  // Trial subtrahend. acc = 3*y*(y+1) is even, so acc+1 is acc with bit 0 set.
  logic [SUM_W-1:0] trial_b;

  // Outcome of the trial subtraction in SUB.
  logic             take;
  logic [WIDTH-1:0] rem_d;
  logic [Y_W-1:0]   y_d;

  assign yp1     = y_q | Y_W'(1);
  assign kmask   = Y_W'(1) << k_q;
  assign pp_bit  = |(yp1 & kmask);
  assign pp      = pp_bit ? (SUM_W'(y_q) << k_q) : '0;
  assign trial_b = (acc_q | SUM_W'(1)) << s_q;

  // A non-negative difference means rem >= b: accept the digit.
  assign take  = ~sum_out[SUM_W-1];
  assign rem_d = take ? sum_out[WIDTH-1:0] : rem_q;
  assign y_d   = y_q | Y_W'(take);

  // Route the shared adder operands for the current state; zero when idle.
  always_comb begin
    sum_in_a = '0;
    sum_in_b = '0;
    unique case (state_q)
      ST_MUL: begin
        sum_in_a = acc_q;
        sum_in_b = pp;
      end
      ST_TRIPLE: begin
        sum_in_a = acc_q;
        sum_in_b = {acc_q[SUM_W-2:0], 1'b0};
      end
      ST_SUB: begin
        sum_in_a = SUM_W'(rem_q);
        sum_in_b = ~trial_b + SUM_W'(1);
      end
      default: begin
        sum_in_a = '0;
        sum_in_b = '0;
      end
    endcase
  end

  // Control FSM with datapath registers and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      rem_q       <= '0;
      y_q         <= '0;
      acc_q       <= '0;
      s_q         <= '0;
      k_q         <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      result_q    <= '0;
      remainder_q <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (start) begin
            rem_q   <= x_i;
            y_q     <= '0;
            s_q     <= S_INIT;
            busy_q  <= 1'b1;
            state_q <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          y_q     <= y_q << 1;
          acc_q   <= '0;
          k_q     <= '0;
          state_q <= ST_MUL;
        end
        ST_MUL: begin
          // Fixed Y_W steps so latency never depends on operand bits.
          acc_q <= sum_out;
          if (k_q == K_LAST) begin
            state_q <= ST_TRIPLE;
          end else begin
            k_q <= k_q + K_W'(1);
          end
        end
        ST_TRIPLE: begin
          acc_q   <= sum_out;
          state_q <= ST_SUB;
        end
        ST_SUB: begin
          rem_q <= rem_d;
          y_q   <= y_d;
          if (s_q == '0) begin
            // Last digit: publish and return to idle on the same edge.
            result_q    <= y_d;
            remainder_q <= rem_d;
            busy_q      <= 1'b0;
            done_q      <= 1'b1;
            state_q     <= ST_IDLE;
          end else begin
            s_q     <= s_q - S_W'(3);
            state_q <= ST_SHIFT;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign result    = result_q;
  assign remainder = remainder_q;

endmodule
`default_nettype wire

// File: tb/tb_cbrt_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cbrt_seq
//  Purpose  : Directed self-checking bench for cbrt_seq at WIDTH=8 and
//             WIDTH=16, each instance with its own shared-adder model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_cbrt_seq;

  logic clk = 1'b0;
  logic rst = 1'b1;

  // WIDTH=8 instance
  logic        start8 = 1'b0;
  logic [7:0]  x8 = '0;
  logic        busy8, done8;
  logic [2:0]  result8;
  logic [7:0]  rem8;
  logic [15:0] sa8, sb8, so8;

  // WIDTH=16 instance
  logic        start16 = 1'b0;
  logic [15:0] x16 = '0;
  logic        busy16, done16;
  logic [5:0]  result16;
  logic [15:0] rem16;
  logic [23:0] sa16, sb16, so16;

  int checks = 0;
  int errors = 0;
  int cyc;

  logic [7:0] cubes [7] = '{8'd0, 8'd1, 8'd8, 8'd27, 8'd64, 8'd125, 8'd216};

  assign so8  = sa8 + sb8;
  assign so16 = sa16 + sb16;

  always #5 clk = ~clk;

  cbrt_seq #(.WIDTH(8), .SUM_W(16)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .x_i(x8),
    .busy(busy8), .done(done8), .result(result8), .remainder(rem8),
    .sum_in_a(sa8), .sum_in_b(sb8), .sum_out(so8)
  );

  cbrt_seq #(.WIDTH(16), .SUM_W(24)) dut16 (
    .clk(clk), .rst(rst), .start(start16), .x_i(x16),
    .busy(busy16), .done(done16), .result(result16), .remainder(rem16),
    .sum_in_a(sa16), .sum_in_b(sb16), .sum_out(so16)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One full WIDTH=8 operation with latency, pulse and result checks.
  task automatic run8(input logic [7:0] x, input logic [2:0] er, input logic [7:0] erem,
                      input string tag);
    int n;
    @(negedge clk); start8 = 1'b1; x8 = x;
    @(negedge clk); start8 = 1'b0; x8 = ~x;
    n = 0;
    while (busy8 === 1'b1 && n < 200) begin
      @(negedge clk); n++;
    end
    chk({tag, " busy_cycles"}, n, 18);
    chk({tag, " done"}, done8, 1);
    chk({tag, " result"}, result8, er);
    chk({tag, " remainder"}, rem8, erem);
    @(negedge clk);
    chk({tag, " done_low"}, done8, 0);
    chk({tag, " idle_sum_a"}, sa8, 0);
    chk({tag, " idle_sum_b"}, sb8, 0);
  endtask

  // One full WIDTH=16 operation.
  task automatic run16(input logic [15:0] x, input logic [5:0] er, input logic [15:0] erem,
                       input string tag);
    int n;
    @(negedge clk); start16 = 1'b1; x16 = x;
    @(negedge clk); start16 = 1'b0; x16 = ~x;
    n = 0;
    while (busy16 === 1'b1 && n < 400) begin
      @(negedge clk); n++;
    end
    chk({tag, " busy_cycles"}, n, 54);
    chk({tag, " done"}, done16, 1);
    chk({tag, " result"}, result16, er);
    chk({tag, " remainder"}, rem16, erem);
    @(negedge clk);
    chk({tag, " done_low"}, done16, 0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset state, applied asynchronously
    #2 rst = 1'b0;
    #1;
    chk("reset busy", busy8, 0);
    chk("reset done", done8, 0);
    chk("reset result", result8, 0);
    chk("reset remainder", rem8, 0);
    chk("reset sum_a", sa8, 0);
    chk("reset sum_b", sb8, 0);
    chk("reset busy16", busy16, 0);
    @(negedge clk);
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
    chk("idle busy", busy8, 0);

    // Perfect cubes 0..216
    for (int i = 0; i < 7; i++) run8(cubes[i], 3'(i), 8'd0, "cube");

    // Non-cube operands
    run8(8'd255, 3'd6, 8'd39, "x255");
    run8(8'd26,  3'd2, 8'd18, "x26");
    run8(8'd28,  3'd3, 8'd1,  "x28");

    // Wide operand
    run16(16'd65535, 6'd40, 16'd1535, "w65535");
    run16(16'd64000, 6'd40, 16'd0,    "w64000");

    // start while busy is ignored
    @(negedge clk); start8 = 1'b1; x8 = 8'd125;
    @(negedge clk); start8 = 1'b0; x8 = 8'd0; cyc = 1;
    repeat (4) begin @(negedge clk); cyc++; end
    start8 = 1'b1; x8 = 8'd8;
    @(negedge clk); cyc++; start8 = 1'b0; x8 = 8'hAA;
    while (done8 !== 1'b1 && cyc < 200) begin @(negedge clk); cyc++; end
    chk("ignore cycles", cyc, 19);
    chk("ignore result", result8, 5);
    chk("ignore remainder", rem8, 0);
    chk("ignore busy_low", busy8, 0);

    // start in the done cycle is accepted
    start8 = 1'b1; x8 = 8'd27;
    @(negedge clk); start8 = 1'b0; x8 = 8'd0; cyc = 1;
    chk("donestart busy", busy8, 1);
    chk("donestart hold_result", result8, 5);
    while (done8 !== 1'b1 && cyc < 200) begin @(negedge clk); cyc++; end
    chk("donestart cycles", cyc, 19);
    chk("donestart result", result8, 3);
    chk("donestart remainder", rem8, 0);

    // Reset mid-operation aborts without a done pulse
    @(negedge clk); start8 = 1'b1; x8 = 8'd216;
    @(negedge clk); start8 = 1'b0;
    repeat (8) @(negedge clk);
    chk("abort busy_before", busy8, 1);
    rst = 1'b0;
    #1;
    chk("abort busy", busy8, 0);
    chk("abort done", done8, 0);
    chk("abort result", result8, 0);
    chk("abort remainder", rem8, 0);
    chk("abort sum_a", sa8, 0);
    @(negedge clk);
    @(negedge clk); rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("abort no_done", done8, 0);
    chk("abort stay_idle", busy8, 0);
    run8(8'd8, 3'd2, 8'd0, "post_reset");

    // Exhaustive sweep against an independent search model
    for (int v = 0; v < 256; v++) begin
      int r;
      r = 0;
      while ((r + 1) * (r + 1) * (r + 1) <= v) r++;
      run8(8'(v), 3'(r), 8'(v - r * r * r), "sweep");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/cbrt_seq.md
Name: cbrt_seq

Overview:
- Parametrised sequential integer cube root unit; successor to the fixed 8-bit cube-root block.
- Computes result = floor(cbrt(x)) and remainder = x - result^3 for a WIDTH-bit unsigned operand.
- Has no internal adder. Every addition goes through the externally shared `sum` adder on the sum_in_a/sum_in_b/sum_out ports, so a datapath can time-share one adder.
- New compared with the fixed block: generic width, a remainder output, a one-cycle done pulse, and defined start-while-busy behaviour.

Parameters:
- WIDTH, 8, operand width in bits (WIDTH >= 3).
- Y_W, (WIDTH+2)/3, result width. Derived value, not to be overridden.
- SUM_W, 16, width of the shared adder port. Must satisfy SUM_W >= 3*Y_W+3. Elaboration-time $error if this is violated.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  request. Sampled on a rising clk edge while idle.
- x_i  in  WIDTH  operand. Captured on an accepted start.
- busy  out  1  high while a computation is in progress.
- done  out  1  one-cycle pulse when result and remainder become valid.
- result  out  Y_W  floor cube root.
- remainder  out  WIDTH  x - result^3.
- sum_in_a  out  SUM_W  adder operand A.
- sum_in_b  out  SUM_W  adder operand B.
- sum_out  in  SUM_W  combinational A+B from the shared adder, modulo 2^SUM_W.

Behaviour:
Reset:
- rst low: async clear of busy, done, result, remainder, sum_in_a, sum_in_b and all internal registers. State = IDLE.
- Reset asserted mid-operation aborts the computation. No done pulse is produced.

Algorithm (digit-by-digit):
- Initialise rem = x, y = 0.
- For s = 3*(Y_W-1) down to 0, step 3:
  - y = 2y.
  - t = y*(y+1).
  - b = (3t+1) << s.
  - If rem >= b: rem = rem - b, y = y + 1.

States:
- IDLE:
  - start=1 -> capture x_i into rem, clear y, set s = 3*(Y_W-1), go to SHIFT, busy=1 from the next cycle.
  - start=0 -> stay in IDLE.
- SHIFT (1 cycle): y <= y<<1; clear the accumulator acc; k <= 0.
- MUL (Y_W cycles, k = 0..Y_W-1):
  - sum_in_a = acc.
  - sum_in_b = (y+1)[k] ? (y<<k) : 0.
  - acc <= sum_out.
  - Fixed cycle count, independent of operand bits.
- TRIPLE (1 cycle): sum_in_a = acc, sum_in_b = acc<<1, acc <= sum_out.
- SUB (1 cycle):
  - sum_in_a = rem, zero-extended.
  - sum_in_b = two's complement of ((acc+1)<<s). The increment and negate are formed locally.
  - If sum_out[SUM_W-1] == 0: rem <= sum_out[WIDTH-1:0] and y[0] <= 1.
  - If s == 0 -> go to FINISH; otherwise s <= s-3 and go to SHIFT.
- FINISH (combined with the last SUB edge):
  - result <= y, remainder <= rem, busy <= 0, done <= 1 for exactly one cycle.
  - Return to IDLE.

Timing:
- busy stays high for exactly Y_W*(Y_W+3) cycles: 18 for WIDTH=8, 54 for WIDTH=16.
- done rises on the same edge that busy falls.
- result and remainder update only at FINISH. They hold their previous values during computation and until the next completion.

Boundary rules:
- start while busy is ignored, and x_i changes while busy have no effect.
- start sampled in the cycle done=1 is accepted, since the block is already in IDLE.
- sum_in_a and sum_in_b are 0 in IDLE.
- No overflow is possible: (3t+1)<<s < 2^(3*Y_W+2), which is below the sign bit of SUM_W.
- x=0 -> result 0, remainder 0, same latency as any other operand.

Test Plan:
- WIDTH=8, x = 0, 1, 8, 27, 64, 125, 216 -> result 0..6, remainder 0, busy high for exactly 18 cycles, one done pulse each.
- WIDTH=8, x=255 -> result 6, remainder 39; x=26 -> result 2, remainder 18; x=28 -> result 3, remainder 1.
- WIDTH=16, SUM_W=24, x=65535 -> result 40, remainder 1535, busy 54 cycles; x=64000 -> result 40, remainder 0.
- Sweep all 256 values at WIDTH=8 against a reference model: result^3 <= x < (result+1)^3 and remainder == x - result^3.
- Start x=125, pulse start with x_i=8 at busy cycle 5 -> ignored, result 5. Then assert start in the done cycle with x=27 -> accepted, result 3.
- Start x=216, drop rst at busy cycle 9 -> busy, done, result and remainder 0 immediately with no clock edge required. Release rst, run x=8 -> result 2 after 18 cycles.
